// File: rtl/pipe_ctrl.sv
// Hazard/sequencing controller for the five-stage core: shadow scoreboard, stalls, redirects, memory freeze, halt.
// Build option: define PIPE_CTRL_FORWARD_EN to enable operand forwarding (load-use is then the only stall).
module pipe_ctrl #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_rs1_used,
    input  logic              id_rs2_used,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_rd_we,
    input  logic              id_is_load,
    input  logic              id_ebreak,
    input  logic              ex_pc_sel,
    input  logic              mem_req,
    input  logic              mem_ready,
    output logic              pc_en,
    output logic              ifid_en,
    output logic              idex_en,
    output logic              exmem_en,
    output logic              memwb_en,
    output logic              ifid_flush,
    output logic              idex_flush,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic              halted,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    typedef struct packed {
        logic              vld;
        logic [REG_AW-1:0] rd;
        logic              we;
        logic              brk;
    } slot_t;

    typedef enum logic [1:0] {RUN, MEM_WAIT, HALT} state_t;

    state_t state, state_nxt;
    slot_t  ex_s, mem_s, wb_s;
    logic   hit_ex, hazard, redirect, freeze, stall_evt, flush_evt;

    // x0 is hardwired, so it never creates a dependency
    function automatic logic hit(input slot_t s, input logic [REG_AW-1:0] rs, input logic used);
        return used && (rs != '0) && s.vld && s.we && (s.rd == rs);
    endfunction

    assign hit_ex   = hit(ex_s, id_rs1, id_rs1_used) || hit(ex_s, id_rs2, id_rs2_used);
    assign redirect = ex_pc_sel && ex_s.vld;

`ifdef PIPE_CTRL_FORWARD_EN
    logic              ex_ld;
    logic [REG_AW-1:0] ex_rs1, ex_rs2;
    logic              ex_rs1_used, ex_rs2_used;

    assign hazard = hit_ex && ex_ld;

    // EX/MEM is the younger producer, so it wins over MEM/WB
    assign fwd_a = !ex_s.vld                         ? 2'd0 :
                   hit(mem_s, ex_rs1, ex_rs1_used)   ? 2'd1 :
                   hit(wb_s,  ex_rs1, ex_rs1_used)   ? 2'd2 : 2'd0;
    assign fwd_b = !ex_s.vld                         ? 2'd0 :
                   hit(mem_s, ex_rs2, ex_rs2_used)   ? 2'd1 :
                   hit(wb_s,  ex_rs2, ex_rs2_used)   ? 2'd2 : 2'd0;

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            ex_ld       <= 1'b0;
            ex_rs1      <= '0;
            ex_rs2      <= '0;
            ex_rs1_used <= 1'b0;
            ex_rs2_used <= 1'b0;
        end else if (idex_en) begin
            ex_ld       <= !idex_flush && id_is_load;
            ex_rs1      <= id_rs1;
            ex_rs2      <= id_rs2;
            ex_rs1_used <= !idex_flush && id_rs1_used;
            ex_rs2_used <= !idex_flush && id_rs2_used;
        end
    end
`else
    logic unused;
    assign unused = id_is_load;

    // regfile write lands at the end of WB, so WB still counts as in flight
    assign hazard = hit_ex ||
                    hit(mem_s, id_rs1, id_rs1_used) || hit(mem_s, id_rs2, id_rs2_used) ||
                    hit(wb_s,  id_rs1, id_rs1_used) || hit(wb_s,  id_rs2, id_rs2_used);
    assign fwd_a  = 2'd0;
    assign fwd_b  = 2'd0;
`endif

    always_comb begin
        state_nxt  = state;
        pc_en      = 1'b1;
        ifid_en    = 1'b1;
        idex_en    = 1'b1;
        exmem_en   = 1'b1;
        memwb_en   = 1'b1;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        halted     = 1'b0;
        freeze     = 1'b0;
        stall_evt  = 1'b0;
        flush_evt  = 1'b0;
        case (state)
            HALT: begin
                {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = '0;
                halted = 1'b1;
            end
            default: begin
                // the cycle mem_ready rises out of MEM_WAIT is an ordinary RUN cycle
                freeze = (state == MEM_WAIT) ? !mem_ready : (mem_req && !mem_ready);
                if (freeze) begin
                    {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = '0;
                    stall_evt = 1'b1;
                end else if (redirect) begin
                    ifid_flush = 1'b1;
                    idex_flush = 1'b1;
                    flush_evt  = 1'b1;
                end else if (hazard) begin
                    pc_en      = 1'b0;
                    ifid_en    = 1'b0;
                    idex_flush = 1'b1;
                    stall_evt  = 1'b1;
                end
                if (wb_s.vld && wb_s.brk) state_nxt = HALT;
                else if (freeze)          state_nxt = MEM_WAIT;
                else                      state_nxt = RUN;
            end
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            state     <= RUN;
            ex_s      <= '0;
            mem_s     <= '0;
            wb_s      <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (idex_en)  ex_s  <= idex_flush ? '0 : slot_t'{1'b1, id_rd, id_rd_we, id_ebreak};
            if (exmem_en) mem_s <= ex_s;
            if (memwb_en) wb_s  <= mem_s;
            if (stall_evt && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
            if (flush_evt && flush_cnt != '1) flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed scenarios plus random traffic against an instruction-level pipeline model.
module tb_pipe_ctrl;
    localparam int AW = 5;
    localparam int CW = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          sys_clk = 1'b0;
    logic          sys_rst = 1'b1;
    logic [AW-1:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;
    logic          id_rs1_used = 0, id_rs2_used = 0, id_rd_we = 0, id_is_load = 0, id_ebreak = 0;
    logic          ex_pc_sel = 0, mem_req = 0, mem_ready = 1;
    logic          pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, halted;
    logic [1:0]    fwd_a, fwd_b;
    logic [CW-1:0] stall_cnt, flush_cnt;

    always #5 sys_clk = ~sys_clk;

    pipe_ctrl #(.REG_AW(AW), .CNT_W(CW)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .id_rd(id_rd), .id_rd_we(id_rd_we), .id_is_load(id_is_load), .id_ebreak(id_ebreak),
        .ex_pc_sel(ex_pc_sel), .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en), .memwb_en(memwb_en),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush), .fwd_a(fwd_a), .fwd_b(fwd_b),
        .halted(halted), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    typedef struct packed {
        logic          vld;
        logic [AW-1:0] rd;
        logic          we, ld, brk, br;
        logic [AW-1:0] rs1, rs2;
        logic          u1, u2;
    } ins_t;

    // instruction-level model: what sits in EX/MEM/WB, plus wait/halt flags
    ins_t   m_ex, m_mem, m_wb, id_cur;
    ins_t   prog[$];
    bit     m_wait, m_halt, rnd_mode;
    int     m_stall, m_flush;
    int     n_tests = 0, n_fail = 0;
    logic [6:0] e_ctl;  // {pc, ifid, idex, exmem, memwb, ifid_flush, idex_flush}
    logic [1:0] e_fa, e_fb;
    logic       e_halt;
    bit         e_st, e_fl, e_fz;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit wr(input ins_t p, input logic [AW-1:0] rs, input logic u);
        return u && rs != 0 && p.vld && p.we && p.rd == rs;
    endfunction

    function automatic logic [1:0] src(input ins_t mm, input ins_t ww, input logic [AW-1:0] rs, input logic u);
        if (wr(mm, rs, u)) return 2'd1;
        if (wr(ww, rs, u)) return 2'd2;
        return 2'd0;
    endfunction

    function automatic ins_t mk(input int rd, input bit we, input bit ld, input int rs1, input bit u1,
                                input int rs2, input bit u2, input bit brk, input bit br);
        ins_t i;
        i = '0;
        i.rd = AW'(rd); i.we = we; i.ld = ld; i.rs1 = AW'(rs1); i.u1 = u1;
        i.rs2 = AW'(rs2); i.u2 = u2; i.brk = brk; i.br = br;
        return i;
    endfunction

    function automatic ins_t next_ins();
        if (prog.size() != 0) return prog.pop_front();
        if (!rnd_mode) return '0;
        return mk($urandom_range(0, 7), $urandom % 2, ($urandom % 4) == 0, $urandom_range(0, 7),
                  $urandom % 2, $urandom_range(0, 7), $urandom % 2, 1'b0, 1'b0);
    endfunction

    task automatic model_out();
        bit hz;
        e_ctl = 7'b1111100; e_halt = 0; e_st = 0; e_fl = 0; e_fz = 0;
`ifdef PIPE_CTRL_FORWARD_EN
        e_fa = m_ex.vld ? src(m_mem, m_wb, m_ex.rs1, m_ex.u1) : 2'd0;
        e_fb = m_ex.vld ? src(m_mem, m_wb, m_ex.rs2, m_ex.u2) : 2'd0;
        hz   = m_ex.ld && (wr(m_ex, id_cur.rs1, id_cur.u1) || wr(m_ex, id_cur.rs2, id_cur.u2));
`else
        e_fa = 2'd0;
        e_fb = 2'd0;
        hz   = wr(m_ex, id_cur.rs1, id_cur.u1)  || wr(m_ex, id_cur.rs2, id_cur.u2)  ||
               wr(m_mem, id_cur.rs1, id_cur.u1) || wr(m_mem, id_cur.rs2, id_cur.u2) ||
               wr(m_wb, id_cur.rs1, id_cur.u1)  || wr(m_wb, id_cur.rs2, id_cur.u2);
`endif
        if (m_halt) begin
            e_ctl = '0; e_halt = 1;
        end else begin
            e_fz = m_wait ? !mem_ready : (mem_req && !mem_ready);
            if (e_fz)                         begin e_ctl = 7'b0000000; e_st = 1; end
            else if (ex_pc_sel && m_ex.vld)   begin e_ctl = 7'b1111111; e_fl = 1; end
            else if (hz)                      begin e_ctl = 7'b0011101; e_st = 1; end
        end
    endtask

    task automatic model_clk();
        if (m_halt) return;
        if (m_wb.vld && m_wb.brk) m_halt = 1;
        m_wait = e_fz;
        if (e_st && m_stall < CMAX) m_stall++;
        if (e_fl && m_flush < CMAX) m_flush++;
        if (e_ctl[2]) m_wb = m_mem;
        if (e_ctl[3]) m_mem = m_ex;
        if (e_ctl[4]) begin
            m_ex = e_ctl[0] ? '0 : id_cur;
            if (!e_ctl[0]) m_ex.vld = 1'b1;
        end
        if (e_ctl[1])      id_cur = '0;
        else if (e_ctl[5]) id_cur = next_ins();
    endtask

    task automatic model_rst();
        m_ex = '0; m_mem = '0; m_wb = '0; id_cur = '0;
        m_wait = 0; m_halt = 0; m_stall = 0; m_flush = 0;
    endtask

    // called at a falling edge: drive, check mid-cycle, advance the model on the rising edge
    task automatic step();
        id_rs1 = id_cur.rs1; id_rs2 = id_cur.rs2; id_rs1_used = id_cur.u1; id_rs2_used = id_cur.u2;
        id_rd = id_cur.rd; id_rd_we = id_cur.we; id_is_load = id_cur.ld; id_ebreak = id_cur.brk;
        ex_pc_sel = rnd_mode ? (($urandom % 6) == 0) : (m_ex.vld && m_ex.br);
        #2;
        model_out();
        chk("ctl", {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush}, e_ctl);
        chk("fwd", {fwd_a, fwd_b}, {e_fa, e_fb});
        chk("halted", halted, e_halt);
        chk("stall_cnt", stall_cnt, m_stall);
        chk("flush_cnt", flush_cnt, m_flush);
        @(posedge sys_clk);
        model_clk();
        @(negedge sys_clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        model_rst();
        rnd_mode = 0;
        #1 sys_rst = 1'b0;
        repeat (2) @(negedge sys_clk);
        chk("rst_ctl", {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush}, 7'b1111100);
        chk("rst_fwd", {fwd_a, fwd_b}, 4'd0);
        chk("rst_halted", halted, 0);
        chk("rst_cnt", {stall_cnt, flush_cnt}, 0);
        sys_rst = 1'b1;

        // independent ALU stream
        for (int i = 0; i < 20; i++) prog.push_back(mk(20 + i % 10, 1, 0, 0, 0, 0, 0, 0, 0));
        repeat (24) step();
        chk("indep_stall", stall_cnt, 0);

        // add x5 ; add x6,x5,x1
        prog.push_back(mk(5, 1, 0, 0, 0, 0, 0, 0, 0));
        prog.push_back(mk(6, 1, 0, 5, 1, 1, 1, 0, 0));
        repeat (8) step();
`ifdef PIPE_CTRL_FORWARD_EN
        chk("raw_stall", stall_cnt, 0);
`else
        chk("raw_stall", stall_cnt, 3);
`endif

        // lw x7 ; add x8,x7,x7
        prog.push_back(mk(7, 1, 1, 0, 0, 0, 0, 0, 0));
        prog.push_back(mk(8, 1, 0, 7, 1, 7, 1, 0, 0));
        repeat (8) step();
`ifdef PIPE_CTRL_FORWARD_EN
        chk("ldu_stall", stall_cnt, 1);
`else
        chk("ldu_stall", stall_cnt, 6);
`endif

        // taken branch writing x9 with a dependent instruction behind it in ID
        prog.push_back(mk(9, 1, 0, 0, 0, 0, 0, 0, 1));
        prog.push_back(mk(10, 1, 0, 9, 1, 0, 0, 0, 0));
        repeat (8) step();
        chk("redir_flush", flush_cnt, 1);
`ifdef PIPE_CTRL_FORWARD_EN
        chk("redir_stall", stall_cnt, 1);
`else
        chk("redir_stall", stall_cnt, 6);
`endif

        // data memory not ready for 4 cycles
        mem_req = 1; mem_ready = 0;
        repeat (4) step();
        mem_ready = 1;
        step();
        mem_req = 0;
        repeat (2) step();
`ifdef PIPE_CTRL_FORWARD_EN
        chk("memw_stall", stall_cnt, 5);
`else
        chk("memw_stall", stall_cnt, 10);
`endif

        // random traffic; counters are narrow so saturation is reached
        rnd_mode = 1;
        repeat (300) begin
            mem_req   = ($urandom % 4) == 0;
            mem_ready = $urandom % 2;
            step();
        end
        rnd_mode = 0; mem_req = 0; mem_ready = 1;
        repeat (6) step();
        chk("stall_sat", stall_cnt, CMAX);
        chk("flush_sat", flush_cnt, CMAX);

        // ebreak retires, core stops until reset
        prog.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0));
        repeat (10) step();
        chk("halt_on", halted, 1);
        chk("halt_ctl", {pc_en, ifid_en, idex_en, exmem_en, memwb_en}, 0);

        // asynchronous reset away from any clock edge
        ex_pc_sel = 0;
        #3 sys_rst = 1'b0;
        #1;
        chk("arst_halted", halted, 0);
        chk("arst_ctl", {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush}, 7'b1111100);
        chk("arst_cnt", {stall_cnt, flush_cnt}, 0);
        model_rst();
        @(negedge sys_clk);
        sys_rst = 1'b1;
        repeat (4) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
